instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding memory requests feeding a 2-entry
// {pc, inst} FIFO toward decode, with redirect handling that drops stale responses.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        stall_id,
    input  logic        branch_taken,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        valid_id
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_inst_q [2];

    logic redirect;
    logic grant;
    logic push;
    logic pop;
    logic in_flight;

    always_comb begin
        imem_req  = rst_n && (state_q == ST_REQ) && (count_q < 2'd2);
        imem_addr = pc_f_q & WORD_MASK;
        valid_id  = rst_n && (count_q != 2'd0);
        inst_id   = valid_id ? fifo_inst_q[rd_ptr_q] : NOP_INST;
        pc_id     = valid_id ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    end

    assign redirect = branch_taken && clk_en;
    assign grant    = imem_req && imem_gnt;
    // A response is still owed after this edge unless it arrives right now.
    assign in_flight = ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rvalid) || grant;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pc_f_d   = pc_f_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push     = 1'b0;
        pop      = 1'b0;

        if (clk_en) begin
            if (redirect) begin
                pc_f_d   = jump_addr & WORD_MASK;
                count_d  = 2'd0;
                wr_ptr_d = 1'b0;
                rd_ptr_d = 1'b0;
                state_d  = in_flight ? ST_DROP : ST_REQ;
            end else begin
                case (state_q)
                    ST_REQ: begin
                        if (grant) begin
                            req_pc_d = pc_f_q;
                            pc_f_d   = pc_f_q + 32'd4;
                            state_d  = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            push    = 1'b1;
                            state_d = ST_REQ;
                        end
                    end
                    ST_DROP: begin
                        if (imem_rvalid) state_d = ST_REQ;
                    end
                    default: state_d = ST_REQ;
                endcase
                pop      = valid_id && !stall_id;
                count_d  = count_q + {1'b0, push} - {1'b0, pop};
                wr_ptr_d = wr_ptr_q ^ push;
                rd_ptr_d = rd_ptr_q ^ pop;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_REQ;
            pc_f_q   <= RESET_PC & WORD_MASK;
            req_pc_q <= 32'h0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_f_q   <= pc_f_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
